hls_chn_o_rsci_fifo: RTL
========================

Name: hls_chn_o_rsci_fifo

Overview:
- Parametrised successor of the single-register output channel interface used by the HLS fp32 cores. It replaces the one-entry stdreg/wait-ctrl/wait-dp trio with one block.
- The core writes results through a stall-style handshake (oswt/wen_comp). Results are buffered in a DEPTH-entry FIFO.
- Results are presented downstream with the valid/ready handshake lz/vz.
- Adds configurable depth, an optional zero-latency bypass, and an occupancy output.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- DEPTH, 2, FIFO entries (>=1; need not be a power of two).
- BYPASS, 0. When 1 and the FIFO is empty, a core write is presented downstream in the same cycle.
- CNTW, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- nvdla_core_clk  in  1  clock; all state updates on the rising edge.
- nvdla_core_rst  in  1  synchronous, active-high reset.
- chn_o_rsci_oswt  in  1  core requests a write this cycle.
- core_wen  in  1  core stage enable; a write is only considered when oswt & core_wen.
- chn_o_rsci_d  in  WIDTH  core write data.
- chn_o_rsci_wen_comp  out  1  write can complete (not full); the core stalls when low.
- chn_o_rsci_bawt  out  1  registered: a write was accepted in the previous cycle.
- chn_o_rsc_z  out  WIDTH  downstream data.
- chn_o_rsc_lz  out  1  downstream valid.
- chn_o_rsc_vz  in  1  downstream ready.
- chn_o_count  out  CNTW  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset, while nvdla_core_rst=1 at a clock edge:
  - count=0, rd_ptr=0, wr_ptr=0, bawt=0.
  - Storage is not reset.
  - While reset is high, wen_comp=0, lz=0 and z=0; all writes and pops are ignored.
  - A reset mid-transfer discards all buffered entries.
- wen_comp = !rst & (count < DEPTH).
  - It depends on registered state only. There is no combinational path from vz to wen_comp.
  - Consequence: when full, a pop and a push cannot occur in the same cycle.
- push = oswt & core_wen & wen_comp.
- Downstream:
  - lz = !rst & ((count != 0) | (BYPASS & count==0 & push)).
  - z = head entry when count != 0; chn_o_rsci_d when bypassing; 0 when lz=0.
  - pop = lz & vz.
- Bypass case (BYPASS=1, count==0, push, vz=1): the word is transferred this cycle and never stored; count is unchanged.
- Bypass with vz=0: the word is stored; count goes to 1; lz stays high next cycle with the same data.
- BYPASS=0: write-to-lz latency is 1 cycle when the FIFO is empty.
- Next count:
  - count+1 on push without pop (excluding the bypass transfer).
  - count-1 on pop without push.
  - Unchanged on both or neither.
- Pointers increment modulo DEPTH with an explicit wrap DEPTH-1 -> 0. wr_ptr advances on a stored push; rd_ptr advances on a pop from storage.
- Order is strictly FIFO. The data on z must hold stable while lz=1 and vz=0.
- bawt <= push (0 in reset).
- chn_o_count = count.
- Simultaneous push and pop at 0 < count < DEPTH: the head is popped, the new word is appended, and count holds.
- DEPTH=1: behaves as the legacy single register. wen_comp=0 while the entry is held.

Decomposition:
- Shared package hls_chn_pkg: function clog2, and the localparam conventions for count width. Nothing block-specific.
- One sub-module, hls_chn_o_fifo_mem:
  - Contains the WIDTH x DEPTH storage array with write port (we, wr_ptr, d) and asynchronous read (rd_ptr, q).
  - Pointer/count control, bypass muxing and handshake logic stay in the top.

Test Plan:
- Reset, then idle: all cycles show lz=0, z=0, wen_comp=1, count=0, bawt=0. With reset held and oswt=1, core_wen=1: nothing is stored and wen_comp=0.
- DEPTH=2, BYPASS=0, vz=0:
  - Write 0x3F800000 then 0x40000000: count goes 1 then 2, wen_comp=0 after the 2nd write, and a 3rd write is stalled.
  - Then set vz=1: the outputs are 0x3F800000 then 0x40000000 in order, and wen_comp returns to 1 the cycle after the first pop.
- DEPTH=3, vz=1 continuous, writes every cycle of 0,1,2,... for 10 words: count stays at 1 after the first cycle, the outputs match the inputs with 1-cycle latency, and the pointers wrap at 3 with no loss.
- BYPASS=1, empty, vz=1, write 0xDEADBEEF: lz=1 and z=0xDEADBEEF in the same cycle, count stays 0, bawt=1 next cycle. Repeat with vz=0: stored, count=1, z holds 0xDEADBEEF until vz=1.
- Fill to DEPTH=4, then assert reset for 1 cycle with vz=1: the next cycle shows count=0, lz=0, and no buffered word is emitted after reset.
- Random oswt/core_wen/vz for 10k cycles against a queue scoreboard:
  - No loss, duplication or reordering.
  - z is stable while lz & !vz.
  - count never exceeds DEPTH.

Source files
------------

// File: rtl/hls_chn_pkg.sv
// Shared helpers for the HLS channel interfaces: constant log2 and
// pointer-width derivation used when sizing counters and pointers.
package hls_chn_pkg;

    // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Pointer width for a DEPTH-entry array; at least one bit so DEPTH=1 still has a port.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/hls_chn_o_fifo_mem.sv
// Storage array for the output channel FIFO: one synchronous write port and
// an asynchronous read port so the head entry is visible without latency.
module hls_chn_o_fifo_mem
    import hls_chn_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int PTRW  = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTRW-1:0]  wr_ptr,
    input  logic [WIDTH-1:0] d,
    input  logic [PTRW-1:0]  rd_ptr,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the entry addressed by wr_ptr; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr] <= d;
        end
    end

    assign q = mem[rd_ptr];

endmodule

// File: rtl/hls_chn_o_rsci_fifo.sv
// Output channel interface for the HLS fp32 cores: core results enter through
// the stall-style oswt/wen_comp handshake, are buffered in a DEPTH-entry FIFO
// and leave through the lz/vz valid/ready handshake. Optional zero-latency
// bypass when the FIFO is empty.
//
// Downstream handshake: lz is valid, vz is ready. A word transfers on a cycle
// where lz & vz. Once lz is high it stays high with z unchanged until that
// transfer happens; lz never depends on vz, and wen_comp depends only on
// registered state, so a full FIFO cannot push and pop in the same cycle.
module hls_chn_o_rsci_fifo
    import hls_chn_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 2,
    parameter int BYPASS = 0,
    parameter int CNTW   = clog2(DEPTH + 1)
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic             chn_o_rsci_oswt,
    input  logic             core_wen,
    input  logic [WIDTH-1:0] chn_o_rsci_d,
    output logic             chn_o_rsci_wen_comp,
    output logic             chn_o_rsci_bawt,
    output logic [WIDTH-1:0] chn_o_rsc_z,
    output logic             chn_o_rsc_lz,
    input  logic             chn_o_rsc_vz,
    output logic [CNTW-1:0]  chn_o_count
);

    localparam int              PTRW     = ptr_width(DEPTH);
    localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(DEPTH);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [PTRW-1:0] PTR_LAST = PTRW'(DEPTH - 1);
    localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);
    localparam bit              BYP_EN   = (BYPASS != 0);

    logic [CNTW-1:0]  count;
    logic [PTRW-1:0]  rd_ptr;
    logic [PTRW-1:0]  wr_ptr;
    logic             bawt_q;
    logic [WIDTH-1:0] head;

    logic wen_comp;
    logic push;
    logic empty;
    logic bypass_act;
    logic lz;
    logic pop;
    logic store;
    logic pop_mem;

    // Handshake decode: accept, present, and split a push into stored vs bypassed.
    always_comb begin
        wen_comp   = 1'b0;
        push       = 1'b0;
        empty      = 1'b0;
        bypass_act = 1'b0;
        lz         = 1'b0;
        pop        = 1'b0;
        store      = 1'b0;
        pop_mem    = 1'b0;
        if (!nvdla_core_rst) begin
            empty      = (count == '0);
            wen_comp   = (count < DEPTH_C);
            push       = chn_o_rsci_oswt & core_wen & wen_comp;
            bypass_act = BYP_EN & empty & push;
            lz         = !empty | bypass_act;
            pop        = lz & chn_o_rsc_vz;
            // A bypassed word that is taken immediately never touches storage.
            store      = push & !(bypass_act & chn_o_rsc_vz);
            pop_mem    = pop & !empty;
        end
    end

    // Occupancy, pointers and the accepted-write flag.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            bawt_q <= 1'b0;
        end else begin
            bawt_q <= push;
            if (store && !pop_mem) begin
                count <= count + CNT_ONE;
            end else if (pop_mem && !store) begin
                count <= count - CNT_ONE;
            end
            if (store) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
            end
            if (pop_mem) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
            end
        end
    end

    hls_chn_o_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTRW  (PTRW)
    ) u_mem (
        .clk    (nvdla_core_clk),
        .we     (store),
        .wr_ptr (wr_ptr),
        .d      (chn_o_rsci_d),
        .rd_ptr (rd_ptr),
        .q      (head)
    );

    assign chn_o_rsci_wen_comp = wen_comp;
    assign chn_o_rsci_bawt     = bawt_q;
    assign chn_o_rsc_lz        = lz;
    assign chn_o_count         = count;
    assign chn_o_rsc_z         = !lz    ? '0 :
                                 !empty ? head : chn_o_rsci_d;

endmodule
